// File: rtl/rv_fetch_queue.sv
// rv_fetch_queue: sequential instruction-fetch front end.
// Issues word fetches under a credit limit, tags in-order responses with
// their PCs and buffers them in a DEPTH-entry circular queue for decode.
// A redirect flushes the queue, reloads the fetch PC and squashes every
// response that is still in flight.
module rv_fetch_queue #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic                     mem_req_valid,
   input  logic                     mem_req_ready,
   output logic [XLEN-1:0]          mem_req_addr,
   input  logic                     mem_rsp_valid,
   input  logic [31:0]              mem_rsp_data,
   input  logic                     redirect_valid,
   input  logic [XLEN-1:0]          redirect_pc,
   output logic                     inst_valid,
   input  logic                     inst_ready,
   output logic [31:0]              inst_data,
   output logic [XLEN-1:0]          inst_pc,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);
   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

   // Architectural state
   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] wr_pc;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   drop_cnt;
   logic [CW-1:0]   count;
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;

   // Queue storage (no reset; validity is tracked by count)
   logic [31:0]     data_mem [DEPTH];
   logic [XLEN-1:0] pc_mem   [DEPTH];

   // Derived control
   logic [CW:0]     credit_sum;
   logic            req_fire;
   logic            rsp_fire;
   logic            do_drop;
   logic            do_write;
   logic            do_pop;
   logic [CW-1:0]   outstanding_next;
   logic [XLEN-1:0] redirect_base;
   logic            unused_pc_bits;

   // Low address bits of a redirect target are discarded by design.
   assign unused_pc_bits = ^redirect_pc[1:0];
   assign redirect_base  = {redirect_pc[XLEN-1:2], 2'b00};

   // Every accepted request owns a queue slot until it is popped or
   // squashed, so a returning response can never find the queue full.
   // Reset holds the request off while rst is low.
   assign credit_sum    = {1'b0, outstanding} + {1'b0, count};
   assign mem_req_valid = rst & (credit_sum < DEPTH_C);
   assign mem_req_addr  = fetch_pc;
   assign req_fire      = mem_req_valid & mem_req_ready;

   // A response with nothing outstanding is a protocol error and is ignored.
   assign rsp_fire = mem_rsp_valid & (outstanding != '0);
   assign do_drop  = rsp_fire & (drop_cnt != '0);
   assign do_write = rsp_fire & (drop_cnt == '0) & ~redirect_valid;
   assign do_pop   = inst_valid & inst_ready & ~redirect_valid;

   assign outstanding_next = outstanding + CW'(req_fire) - CW'(rsp_fire);

   assign inst_valid = (count != '0);
   assign inst_data  = data_mem[rd_ptr];
   assign inst_pc    = pc_mem[rd_ptr];
   assign occupancy  = count;

   // Fetch, squash and queue bookkeeping; redirect overrides everything
   // except the in-flight count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc    <= RESET_PC;
         wr_pc       <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
         count       <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
      end else begin
         outstanding <= outstanding_next;
         if (redirect_valid) begin
            fetch_pc <= redirect_base;
            wr_pc    <= redirect_base;
            drop_cnt <= outstanding_next;
            count    <= '0;
            rd_ptr   <= wr_ptr;
         end else begin
            if (req_fire) begin
               fetch_pc <= fetch_pc + PC_STEP;
            end
            if (do_drop) begin
               drop_cnt <= drop_cnt - CW'(1);
            end
            if (do_write) begin
               wr_pc  <= wr_pc + PC_STEP;
               wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
               rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(do_write) - CW'(do_pop);
         end
      end
   end

   // Queue write port: instruction word plus the PC it was fetched from.
   always_ff @(posedge clk) begin
      if (do_write) begin
         data_mem[wr_ptr] <= mem_rsp_data;
         pc_mem[wr_ptr]   <= wr_pc;
      end
   end

endmodule

// File: tb/tb_rv_fetch_queue.sv
// tb_rv_fetch_queue: directed bench with an in-order 1-cycle memory model
// and a scoreboard of expected {pc, data} queue entries.
module tb_rv_fetch_queue;

   localparam int          DEPTH = 4;
   localparam logic [31:0] RPC   = 32'h100;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b0;
   logic [31:0] mem_req_addr;
   logic        mem_rsp_valid = 1'b0;
   logic [31:0] mem_rsp_data  = 32'h0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc    = 32'h0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic [2:0]  occupancy;

   always #5 clk = ~clk;

   rv_fetch_queue #(
      .XLEN(32),
      .DEPTH(DEPTH),
      .RESET_PC(RPC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .mem_req_valid(mem_req_valid),
      .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr),
      .mem_rsp_valid(mem_rsp_valid),
      .mem_rsp_data(mem_rsp_data),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .inst_valid(inst_valid),
      .inst_ready(inst_ready),
      .inst_data(inst_data),
      .inst_pc(inst_pc),
      .occupancy(occupancy)
   );

   typedef struct {logic [31:0] addr; bit stale;} req_t;
   typedef struct {logic [31:0] pc; logic [31:0] data;} ent_t;

   req_t        pend[$];   // requests accepted by memory, not yet answered
   ent_t        exp_q[$];  // entries the DUT queue should hold, head first
   logic [31:0] fpc = RPC; // model fetch address
   int          errors   = 0;
   int          checks   = 0;
   int          fire_cnt = 0;
   bit          last_pop_valid = 1'b0;
   logic [31:0] last_pop_pc    = 32'h0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
      end
   endtask

   // One clock cycle: drive inputs, check outputs at the falling edge,
   // advance the model to match the coming rising edge.
   task automatic step(input bit rdy, input bit irdy, input bit rsp_en,
                       input bit redir, input logic [31:0] rpc);
      bit   rsp_now;
      bit   fire;
      bit   pop;
      bit   exp_rv;
      bit   exp_iv;
      req_t r;
      ent_t e;
      mem_req_ready  = rdy;
      inst_ready     = irdy;
      redirect_valid = redir;
      redirect_pc    = rpc;
      rsp_now        = rsp_en && rst && (pend.size() > 0);
      mem_rsp_valid  = rsp_now;
      mem_rsp_data   = rsp_now ? mem_word(pend[0].addr) : 32'h0;
      assert (!(mem_rsp_valid && pend.size() == 0))
         else $error("FAIL protocol response_without_request");
      @(negedge clk);
      if (!rst) begin
         chk("rst_req_valid", 32'(mem_req_valid), 32'h0);
         chk("rst_inst_valid", 32'(inst_valid), 32'h0);
         chk("rst_occupancy", 32'(occupancy), 32'h0);
         chk("rst_req_addr", mem_req_addr, RPC);
      end else begin
         exp_rv = (pend.size() + exp_q.size()) < DEPTH;
         exp_iv = exp_q.size() > 0;
         chk("req_valid", 32'(mem_req_valid), 32'(exp_rv));
         chk("req_addr", mem_req_addr, fpc);
         chk("occupancy", 32'(occupancy), 32'(exp_q.size()));
         chk("inst_valid", 32'(inst_valid), 32'(exp_iv));
         if (exp_iv) begin
            chk("inst_pc", inst_pc, exp_q[0].pc);
            chk("inst_data", inst_data, exp_q[0].data);
         end
         fire = exp_rv && rdy;
         pop  = exp_iv && irdy;
         if (fire) fire_cnt++;
         if (redir) begin
            if (rsp_now) r = pend.pop_front();
            if (fire) begin
               r.addr  = fpc;
               r.stale = 1'b1;
               pend.push_back(r);
            end
            foreach (pend[i]) pend[i].stale = 1'b1;
            exp_q.delete();
            fpc = {rpc[31:2], 2'b00};
            $display("redirect to 0x%08h, %0d in flight squashed", fpc, pend.size());
         end else begin
            if (pop) begin
               e = exp_q.pop_front();
               if (last_pop_valid && last_pop_pc == 32'hFFFF_FFFC)
                  chk("wrap_pc", inst_pc, 32'h0);
               last_pop_valid = 1'b1;
               last_pop_pc    = e.pc;
               $display("pop pc=0x%08h data=0x%08h", inst_pc, inst_data);
            end
            if (rsp_now) begin
               r = pend.pop_front();
               if (!r.stale) begin
                  e.pc   = r.addr;
                  e.data = mem_word(r.addr);
                  exp_q.push_back(e);
               end
            end
            if (fire) begin
               r.addr  = fpc;
               r.stale = 1'b0;
               pend.push_back(r);
               fpc = fpc + 32'd4;
            end
         end
      end
      @(posedge clk);
      #1;
      mem_rsp_valid  = 1'b0;
      redirect_valid = 1'b0;
   endtask

   initial begin
      // Reset held, then released
      step(1, 1, 1, 0, 32'h0);
      step(1, 1, 1, 0, 32'h0);
      rst = 1'b1;
      chk("first_addr", mem_req_addr, 32'h100);

      // Streaming with a 1-cycle memory and an always-ready decoder
      for (int i = 0; i < 10; i++) begin
         step(1, 1, 1, 0, 32'h0);
         chk("occ_le1", 32'(occupancy <= 1), 32'h1);
      end

      // Drain, then fill with decoder stalled: credit limit caps fetches
      repeat (4) step(0, 1, 1, 0, 32'h0);
      fire_cnt = 0;
      repeat (8) step(1, 0, 1, 0, 32'h0);
      chk("fill_fires", 32'(fire_cnt), 32'd4);
      chk("full_occ", 32'(occupancy), 32'd4);
      chk("full_req_valid", 32'(mem_req_valid), 32'h0);
      fire_cnt = 0;
      step(1, 1, 1, 0, 32'h0);
      repeat (4) step(1, 0, 1, 0, 32'h0);
      chk("refill_fires", 32'(fire_cnt), 32'd1);
      chk("refill_occ", 32'(occupancy), 32'd4);

      // Redirect with two in flight and a third firing in the same cycle
      repeat (6) step(0, 1, 1, 0, 32'h0);
      step(0, 1, 1, 1, 32'h200);
      step(1, 1, 0, 0, 32'h0);
      step(1, 1, 0, 0, 32'h0);
      step(1, 1, 0, 1, 32'h403);
      chk("redir_addr", mem_req_addr, 32'h400);
      for (int i = 0; i < 20 && !inst_valid; i++) step(1, 0, 1, 0, 32'h0);
      chk("redir_first_valid", 32'(inst_valid), 32'h1);
      chk("redir_first_pc", inst_pc, 32'h400);

      // Redirect coinciding with a response and a pop, two entries queued
      repeat (8) step(0, 1, 1, 0, 32'h0);
      repeat (3) step(1, 0, 1, 0, 32'h0);
      chk("pre_flush_occ", 32'(occupancy), 32'd2);
      step(1, 1, 1, 1, 32'h600);
      chk("flush_occ", 32'(occupancy), 32'd0);
      chk("flush_inst_valid", 32'(inst_valid), 32'h0);
      for (int i = 0; i < 20 && !inst_valid; i++) step(1, 0, 1, 0, 32'h0);
      chk("flush_first_pc", inst_pc, 32'h600);

      // Address wrap at the top of the 32-bit space
      repeat (8) step(0, 1, 1, 0, 32'h0);
      step(0, 1, 1, 1, 32'hFFFF_FFF8);
      repeat (10) step(1, 1, 1, 0, 32'h0);

      // Asynchronous reset in the middle of traffic
      repeat (3) step(1, 0, 0, 0, 32'h0);
      step(1, 0, 1, 0, 32'h0);
      #2;
      rst = 1'b0;
      #1;
      chk("async_req_valid", 32'(mem_req_valid), 32'h0);
      chk("async_inst_valid", 32'(inst_valid), 32'h0);
      chk("async_occupancy", 32'(occupancy), 32'h0);
      chk("async_req_addr", mem_req_addr, RPC);
      pend.delete();
      exp_q.delete();
      fpc = RPC;
      last_pop_valid = 1'b0;
      step(1, 1, 1, 0, 32'h0);
      step(1, 1, 1, 0, 32'h0);
      rst = 1'b1;
      chk("restart_addr", mem_req_addr, RPC);
      repeat (6) step(1, 1, 1, 0, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
